// File: rtl/pump_pkg.sv
// Shared types and constants for the animated pump attack: states, directions,
// keycodes, playfield defaults and the reach bounds check.
package pump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXTEND,
        HOLD,
        RETRACT,
        COOLDOWN
    } pump_state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } pump_dir_t;

    localparam logic [7:0] KEY_W = 8'd26;
    localparam logic [7:0] KEY_S = 8'd22;
    localparam logic [7:0] KEY_A = 8'd4;
    localparam logic [7:0] KEY_D = 8'd7;

    localparam int DEFAULT_PLAY_W = 512;
    localparam int DEFAULT_PLAY_H = 480;

    // True when a pump of reach len fits inside the playfield; 11-bit math so
    // Y+L and X+L never wrap.
    function automatic logic reach_ok(
        input pump_dir_t   dir,
        input logic [9:0]  x,
        input logic [9:0]  y,
        input logic [10:0] len,
        input logic [10:0] play_w,
        input logic [10:0] play_h
    );
        logic ok;
        case (dir)
            DIR_UP:    ok = ({1'b0, y} >= len);
            DIR_DOWN:  ok = (({1'b0, y} + len) < play_h);
            DIR_LEFT:  ok = ({1'b0, x} >= len);
            default:   ok = (({1'b0, x} + len) < play_w);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Rising-edge detector turning the slow, level frame_clk into a one-cycle
// frame_tick in the Clk domain.
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick
);

    logic frame_clk_reg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_clk_reg <= 1'b0;
        end else begin
            frame_clk_reg <= frame_clk;
        end
    end

    assign frame_tick = frame_clk & ~frame_clk_reg;

endmodule

// File: rtl/pump_ctrl.sv
// Frame-rate pump animation: fires from IDLE, extends by STEP per frame, holds
// (optionally attached to an enemy), retracts, then sits out a cooldown.
module pump_ctrl
    import pump_pkg::*;
#(
    parameter int STEP            = 4,
    parameter int MIN_LEN         = 8,
    parameter int MAX_LEN         = 24,
    parameter int COOLDOWN_FRAMES = 4,
    parameter int PLAY_W          = DEFAULT_PLAY_W,
    parameter int PLAY_H          = DEFAULT_PLAY_H
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       pump_enable,
    input  logic [7:0] last_key_press,
    input  logic [9:0] Ball_X_Loc,
    input  logic [9:0] Ball_Y_Loc,
    input  logic       enemy_hit,
    output logic       pump_active,
    output logic [1:0] pump_dir,
    output logic [4:0] pump_len,
    output logic [9:0] pump_tip_x,
    output logic [9:0] pump_tip_y,
    output logic       pump_attached
);

    localparam int CNT_W = $clog2(COOLDOWN_FRAMES + 2);
    localparam logic [10:0] PW = 11'(PLAY_W);
    localparam logic [10:0] PH = 11'(PLAY_H);

    pump_state_t      state_reg;
    logic [CNT_W-1:0] cool_cnt_reg;
    logic             hit_pending_reg;
    logic             frame_tick;

    logic             key_valid;
    pump_dir_t        key_dir;
    logic [10:0]      grow_len;
    logic             fire_ok;
    logic             grow_ok;
    logic             shrink_done;

    frame_tick_gen u_frame_tick_gen (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    always_comb begin
        key_valid = 1'b1;
        key_dir   = DIR_UP;
        case (last_key_press)
            KEY_W:   key_dir = DIR_UP;
            KEY_S:   key_dir = DIR_DOWN;
            KEY_A:   key_dir = DIR_LEFT;
            KEY_D:   key_dir = DIR_RIGHT;
            default: key_valid = 1'b0;
        endcase
    end

    assign grow_len    = {6'd0, pump_len} + 11'(STEP);
    assign fire_ok     = key_valid &&
                         reach_ok(key_dir, Ball_X_Loc, Ball_Y_Loc, 11'(MIN_LEN), PW, PH);
    assign grow_ok     = (grow_len <= 11'(MAX_LEN)) &&
                         reach_ok(pump_dir_t'(pump_dir), Ball_X_Loc, Ball_Y_Loc, grow_len, PW, PH);
    assign shrink_done = ({6'd0, pump_len} <= 11'(MIN_LEN + STEP));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg       <= IDLE;
            cool_cnt_reg    <= '0;
            hit_pending_reg <= 1'b0;
            pump_active     <= 1'b0;
            pump_dir        <= 2'd0;
            pump_len        <= 5'd0;
            pump_attached   <= 1'b0;
        end else begin
            // A hit only survives until the next frame; same-cycle hits are dropped.
            if (frame_tick) begin
                hit_pending_reg <= 1'b0;
            end else if (enemy_hit) begin
                hit_pending_reg <= 1'b1;
            end

            if (frame_tick) begin
                case (state_reg)
                    IDLE: begin
                        if (pump_enable && fire_ok) begin
                            pump_dir    <= key_dir;
                            pump_len    <= 5'(MIN_LEN);
                            pump_active <= 1'b1;
                            state_reg   <= EXTEND;
                        end
                    end
                    EXTEND: begin
                        if (!pump_enable) begin
                            state_reg <= RETRACT;
                        end else if (hit_pending_reg) begin
                            pump_attached <= 1'b1;
                            state_reg     <= HOLD;
                        end else if (grow_ok) begin
                            pump_len <= grow_len[4:0];
                        end else begin
                            state_reg <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (!pump_enable) begin
                            pump_attached <= 1'b0;
                            state_reg     <= RETRACT;
                        end
                    end
                    RETRACT: begin
                        if (shrink_done) begin
                            pump_len     <= 5'd0;
                            pump_active  <= 1'b0;
                            cool_cnt_reg <= CNT_W'(COOLDOWN_FRAMES);
                            state_reg    <= COOLDOWN;
                        end else begin
                            pump_len <= pump_len - 5'(STEP);
                        end
                    end
                    COOLDOWN: begin
                        if (cool_cnt_reg <= CNT_W'(1)) begin
                            cool_cnt_reg <= '0;
                            state_reg    <= IDLE;
                        end else begin
                            cool_cnt_reg <= cool_cnt_reg - CNT_W'(1);
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    // Tip tracks the live ball position every cycle so movement drags the pump.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pump_tip_x <= 10'd0;
            pump_tip_y <= 10'd0;
        end else begin
            pump_tip_x <= Ball_X_Loc;
            pump_tip_y <= Ball_Y_Loc;
            if (pump_active) begin
                case (pump_dir)
                    2'd0: pump_tip_y <= Ball_Y_Loc - {5'd0, pump_len};
                    2'd1: pump_tip_y <= Ball_Y_Loc + {5'd0, pump_len};
                    2'd2: pump_tip_x <= Ball_X_Loc - {5'd0, pump_len};
                    2'd3: pump_tip_x <= Ball_X_Loc + {5'd0, pump_len};
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pump_ctrl.sv
// Bench for pump_ctrl: a table of per-frame vectors, a hand-written reset
// sequence, then randomized frames checked against a behavioural model.
module tb_pump_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       pump_enable;
    logic [7:0] last_key_press;
    logic [9:0] Ball_X_Loc;
    logic [9:0] Ball_Y_Loc;
    logic       enemy_hit;
    logic       pump_active;
    logic [1:0] pump_dir;
    logic [4:0] pump_len;
    logic [9:0] pump_tip_x;
    logic [9:0] pump_tip_y;
    logic       pump_attached;

    int tests = 0;
    int fails = 0;

    pump_ctrl dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_clk      (frame_clk),
        .pump_enable    (pump_enable),
        .last_key_press (last_key_press),
        .Ball_X_Loc     (Ball_X_Loc),
        .Ball_Y_Loc     (Ball_Y_Loc),
        .enemy_hit      (enemy_hit),
        .pump_active    (pump_active),
        .pump_dir       (pump_dir),
        .pump_len       (pump_len),
        .pump_tip_x     (pump_tip_x),
        .pump_tip_y     (pump_tip_y),
        .pump_attached  (pump_attached)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit         en;
        bit         hit;
        logic [7:0] key;
        int         x;
        int         y;
        bit         act;
        int         len;
        bit         att;
        int         tx;
        int         ty;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: pump described by flags and a frame countdown.
    int m_len, m_dir, m_cool;
    bit m_act, m_att, m_grow, m_shrink, m_hitp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input bit en, input bit hit, input logic [7:0] key, input int x, input int y,
                       input bit act, input int len, input bit att, input int tx, input int ty);
        vec_t v;
        v.en = en; v.hit = hit; v.key = key; v.x = x; v.y = y;
        v.act = act; v.len = len; v.att = att; v.tx = tx; v.ty = ty;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    // Drive one frame: inputs, optional hit pulse, a frame_clk pulse, settle.
    task automatic apply(input bit en, input bit hit, input logic [7:0] key, input int x, input int y);
        @(negedge Clk);
        pump_enable    = en;
        last_key_press = key;
        Ball_X_Loc     = 10'(x);
        Ball_Y_Loc     = 10'(y);
        if (hit) begin
            enemy_hit = 1'b1;
            @(negedge Clk);
            enemy_hit = 1'b0;
        end
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk);
        @(negedge Clk) frame_clk = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
    endtask

    function automatic int key_to_dir(input logic [7:0] key);
        case (key)
            8'd26: return 0;
            8'd22: return 1;
            8'd4:  return 2;
            8'd7:  return 3;
            default: return -1;
        endcase
    endfunction

    function automatic bit fits(input int dir, input int x, input int y, input int l);
        case (dir)
            0: return y >= l;
            1: return y + l < 480;
            2: return x >= l;
            default: return x + l < 512;
        endcase
    endfunction

    task automatic model_reset();
        m_len = 0; m_dir = 0; m_cool = 0;
        m_act = 0; m_att = 0; m_grow = 0; m_shrink = 0; m_hitp = 0;
    endtask

    task automatic model_frame(input bit en, input logic [7:0] key, input int x, input int y);
        int d;
        int nxt;
        if (m_cool > 0) begin
            m_cool--;
        end else if (!m_act) begin
            d = key_to_dir(key);
            if (en && d >= 0 && fits(d, x, y, 8)) begin
                m_act = 1; m_len = 8; m_dir = d; m_grow = 1;
            end
        end else if (m_shrink) begin
            if (m_len - 4 <= 8) begin
                m_len = 0; m_act = 0; m_shrink = 0; m_cool = 4;
            end else begin
                m_len -= 4;
            end
        end else if (m_grow) begin
            nxt = m_len + 4;
            if (!en) begin
                m_grow = 0; m_shrink = 1;
            end else if (m_hitp) begin
                m_grow = 0; m_att = 1;
            end else if (nxt > 24 || !fits(m_dir, x, y, nxt)) begin
                m_grow = 0;
            end else begin
                m_len = nxt;
            end
        end else if (!en) begin
            m_shrink = 1; m_att = 0;
        end
        m_hitp = 0;
    endtask

    task automatic model_tip(input int x, input int y, output int tx, output int ty);
        tx = x; ty = y;
        if (m_act) begin
            case (m_dir)
                0: ty = (y - m_len) & 1023;
                1: ty = (y + m_len) & 1023;
                2: tx = (x - m_len) & 1023;
                default: tx = (x + m_len) & 1023;
            endcase
        end
    endtask

    initial begin
        int tx, ty, x, y, r;
        bit en, hit;
        logic [7:0] key;

        Reset = 1'b1; frame_clk = 1'b0; pump_enable = 1'b0; enemy_hit = 1'b0;
        last_key_press = 8'd0; Ball_X_Loc = 10'd0; Ball_Y_Loc = 10'd0;
        @(negedge Clk);
        check("reset_active", pump_active, 0);
        check("reset_len", pump_len, 0);
        check("reset_dir", pump_dir, 0);
        check("reset_attached", pump_attached, 0);
        check("reset_tip_x", pump_tip_x, 0);
        check("reset_tip_y", pump_tip_y, 0);
        do_reset();

        // Fire right to full reach, hold, retract, cooldown.
        add(1,0,7,100,200, 1, 8,0,108,200);
        add(1,0,7,100,200, 1,12,0,112,200);
        add(1,0,7,100,200, 1,16,0,116,200);
        add(1,0,7,100,200, 1,20,0,120,200);
        add(1,0,7,100,200, 1,24,0,124,200);
        add(1,0,7,100,200, 1,24,0,124,200);
        add(0,0,7,100,200, 1,24,0,124,200);
        add(0,0,7,100,200, 1,20,0,120,200);
        add(0,0,7,100,200, 1,16,0,116,200);
        add(0,0,7,100,200, 1,12,0,112,200);
        add(0,0,7,100,200, 0, 0,0,100,200);
        for (int i = 0; i < 4; i++) add(0,0,7,100,200, 0,0,0,100,200);
        // Boundary stop near the top edge, then no fire at y=5.
        add(1,0,26,100,10, 1,8,0,100,2);
        add(1,0,26,100,10, 1,8,0,100,2);
        add(1,0,26,100,10, 1,8,0,100,2);
        add(0,0,26,100,10, 1,8,0,100,2);
        add(0,0,26,100,10, 0,0,0,100,10);
        for (int i = 0; i < 4; i++) add(0,0,26,100,10, 0,0,0,100,10);
        add(1,0,26,100,5, 0,0,0,100,5);
        add(1,0,26,100,5, 0,0,0,100,5);
        // Invalid key.
        add(1,0,44,100,200, 0,0,0,100,200);
        add(1,0,44,100,200, 0,0,0,100,200);
        // Hit during extension at len 16, ignored hit in HOLD, release.
        add(1,0,4,100,200, 1, 8,0,92,200);
        add(1,0,4,100,200, 1,12,0,88,200);
        add(1,0,4,100,200, 1,16,0,84,200);
        add(1,1,4,100,200, 1,16,1,84,200);
        add(1,0,4,100,200, 1,16,1,84,200);
        add(1,1,4,100,200, 1,16,1,84,200);
        add(0,0,4,100,200, 1,16,0,84,200);
        add(0,0,4,100,200, 1,12,0,88,200);
        add(0,0,4,100,200, 0, 0,0,100,200);
        for (int i = 0; i < 4; i++) add(0,0,4,100,200, 0,0,0,100,200);
        // Early release, enable held through cooldown refires on first IDLE frame.
        add(1,0,22,100,200, 1, 8,0,100,208);
        add(1,0,22,100,200, 1,12,0,100,212);
        add(0,0,22,100,200, 1,12,0,100,212);
        add(0,0,22,100,200, 0, 0,0,100,200);
        for (int i = 0; i < 4; i++) add(1,0,22,100,200, 0,0,0,100,200);
        add(1,0,22,100,200, 1, 8,0,100,208);
        add(0,0,22,100,200, 1, 8,0,100,208);
        add(0,0,22,100,200, 0, 0,0,100,200);
        for (int i = 0; i < 4; i++) add(0,0,22,100,200, 0,0,0,100,200);
        // Hit and release on the same frame: release wins.
        add(1,0,7,100,200, 1,8,0,108,200);
        add(0,1,7,100,200, 1,8,0,108,200);
        add(0,0,7,100,200, 0,0,0,100,200);
        for (int i = 0; i < 4; i++) add(0,0,7,100,200, 0,0,0,100,200);

        foreach (vecs[i]) begin
            apply(vecs[i].en, vecs[i].hit, vecs[i].key, vecs[i].x, vecs[i].y);
            $display("[TB] vec %0d en=%0d hit=%0d key=%0d ball=(%0d,%0d) act=%0d len=%0d att=%0d tip=(%0d,%0d)",
                     i, vecs[i].en, vecs[i].hit, vecs[i].key, vecs[i].x, vecs[i].y,
                     pump_active, pump_len, pump_attached, pump_tip_x, pump_tip_y);
            check($sformatf("vec%0d_active", i), pump_active, vecs[i].act);
            check($sformatf("vec%0d_len", i), pump_len, vecs[i].len);
            check($sformatf("vec%0d_attached", i), pump_attached, vecs[i].att);
            check($sformatf("vec%0d_tip_x", i), pump_tip_x, vecs[i].tx);
            check($sformatf("vec%0d_tip_y", i), pump_tip_y, vecs[i].ty);
        end

        // Asynchronous reset while holding at full reach.
        for (int i = 0; i < 6; i++) apply(1, 0, 7, 100, 200);
        check("hold_len_before_reset", pump_len, 24);
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        $display("[TB] async reset in HOLD act=%0d len=%0d dir=%0d tip=(%0d,%0d)",
                 pump_active, pump_len, pump_dir, pump_tip_x, pump_tip_y);
        check("async_reset_active", pump_active, 0);
        check("async_reset_len", pump_len, 0);
        check("async_reset_dir", pump_dir, 0);
        check("async_reset_attached", pump_attached, 0);
        check("async_reset_tip_x", pump_tip_x, 0);
        check("async_reset_tip_y", pump_tip_y, 0);
        @(negedge Clk);
        Reset = 1'b0;
        apply(1, 0, 7, 100, 200);
        $display("[TB] fire after reset act=%0d len=%0d", pump_active, pump_len);
        check("refire_after_reset_len", pump_len, 8);
        apply(0, 0, 7, 100, 200);

        // Randomized frames against the model.
        do_reset();
        model_reset();
        x = 100; y = 200;
        for (int i = 0; i < 300; i++) begin
            en = ($urandom_range(0, 3) != 0);
            hit = ($urandom_range(0, 5) == 0);
            r = $urandom_range(0, 5);
            case (r)
                0: key = 8'd26;
                1: key = 8'd22;
                2: key = 8'd4;
                3: key = 8'd7;
                4: key = 8'd44;
                default: key = last_key_press;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                x = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 30) : $urandom_range(480, 511);
                y = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 30) : $urandom_range(440, 479);
                if ($urandom_range(0, 2) == 0) begin
                    x = $urandom_range(0, 511);
                    y = $urandom_range(0, 479);
                end
            end
            apply(en, hit, key, x, y);
            if (hit) m_hitp = 1;
            model_frame(en, key, x, y);
            model_tip(x, y, tx, ty);
            $display("[TB] rnd %0d en=%0d hit=%0d key=%0d ball=(%0d,%0d) act=%0d len=%0d att=%0d tip=(%0d,%0d)",
                     i, en, hit, key, x, y, pump_active, pump_len, pump_attached, pump_tip_x, pump_tip_y);
            check($sformatf("rnd%0d_active", i), pump_active, m_act);
            check($sformatf("rnd%0d_len", i), pump_len, m_len);
            check($sformatf("rnd%0d_attached", i), pump_attached, m_att);
            check($sformatf("rnd%0d_tip_x", i), pump_tip_x, tx);
            check($sformatf("rnd%0d_tip_y", i), pump_tip_y, ty);
            if (m_act) check($sformatf("rnd%0d_dir", i), pump_dir, m_dir);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
